// File: rtl/xnor_parity_pkg.sv
// rtl/xnor_parity_pkg.sv - shared types and helpers for the XNOR-parity link
package xnor_parity_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

    // Zero-extension does not change the XOR reduction, so narrower words may be passed in.
    function automatic logic xnor_parity(input logic [63:0] data);
        return ~(^data);
    endfunction

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/xnor_parity_acc.sv
// rtl/xnor_parity_acc.sv - running XOR accumulator with clear/load/update
module xnor_parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_update,
    input  logic i_bit,
    output logic o_acc
);

    logic r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 1'b0;
        end else if (i_clear) begin
            r_acc <= 1'b0;
        end else if (i_load) begin
            r_acc <= i_bit;
        end else if (i_update) begin
            r_acc <= r_acc ^ i_bit;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/xnor_parity_rx.sv
// rtl/xnor_parity_rx.sv - serial receiver/checker for XNOR-parity-protected words
module xnor_parity_rx
    import xnor_parity_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin_valid,
    input  logic              sin_start,
    input  logic              sin_bit,
    output logic              sin_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              frame_err,
    output logic [CNT_W-1:0]  perr_cnt
);

    localparam int            CW   = cnt_width(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W);

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_next;
    logic                w_acc;
    logic                w_acc_load;
    logic                w_acc_update;
    logic                w_take;
    logic                w_load_out;
    logic                w_frame_err;
    logic                w_perr;
    logic                r_frame_err;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_perr;
    logic [CNT_W-1:0]    r_perr_cnt;

    // Only the parity bit can stall: it needs a free output register to land in.
    assign sin_ready = !((r_state == PAR) && r_out_valid && !out_ready);
    assign w_take    = sin_valid && sin_ready;
    assign w_perr    = xnor_parity(64'({w_acc, sin_bit}));

    xnor_parity_acc u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_load_out),
        .i_load   (w_acc_load),
        .i_update (w_acc_update),
        .i_bit    (sin_bit),
        .o_acc    (w_acc)
    );

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_acc_load   = 1'b0;
        w_acc_update = 1'b0;
        w_load_out   = 1'b0;
        w_frame_err  = 1'b0;
        if (w_take) begin
            if (sin_start) begin
                // A start bit always opens a new frame, abandoning any partial one.
                w_frame_err     = (r_state != IDLE);
                w_shift_next    = '0;
                w_shift_next[0] = sin_bit;
                w_acc_load      = 1'b1;
                w_cnt_next      = CW'(1);
                w_next          = (DATA_W == 1) ? PAR : DATA;
            end else begin
                case (r_state)
                    IDLE: w_frame_err = 1'b1;
                    DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_cnt == CW'(i)) w_shift_next[i] = sin_bit;
                        end
                        w_acc_update = 1'b1;
                        w_cnt_next   = r_cnt + CW'(1);
                        if (w_cnt_next == LAST) w_next = PAR;
                    end
                    PAR: begin
                        w_load_out = 1'b1;
                        w_cnt_next = '0;
                        w_next     = IDLE;
                    end
                    default: w_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
            r_perr_cnt  <= '0;
        end else begin
            r_frame_err <= w_frame_err;
            if (w_load_out) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_shift;
                r_out_perr  <= w_perr;
                if (w_perr && (r_perr_cnt != '1)) r_perr_cnt <= r_perr_cnt + CNT_W'(1);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_perr  = r_out_perr;
    assign frame_err = r_frame_err;
    assign perr_cnt  = r_perr_cnt;

endmodule

// File: tb/tb_xnor_parity_rx.sv
// tb/tb_xnor_parity_rx.sv - directed self-checking bench for xnor_parity_rx
module tb_xnor_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sin_start = 1'b0;
    logic       sin_bit = 1'b0;
    logic       sin_ready;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_data;
    logic       out_perr;
    logic       frame_err;
    logic [7:0] perr_cnt;

    int errors = 0;
    int checks = 0;

    xnor_parity_rx #(.DATA_W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin_valid (sin_valid),
        .sin_start (sin_start),
        .sin_bit   (sin_bit),
        .sin_ready (sin_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_perr  (out_perr),
        .frame_err (frame_err),
        .perr_cnt  (perr_cnt)
    );

    always #5 clk = ~clk;

    task automatic send_bit(input logic start, input logic b);
        @(negedge clk);
        sin_valid = 1'b1;
        sin_start = start;
        sin_bit   = b;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin_start = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p);
        send_bit(1'b1, d[0]);
        for (int i = 1; i < 4; i++) send_bit(1'b0, d[i]);
        send_bit(1'b0, p);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sin_ready !== 1'b1) begin errors++; $display("FAIL reset_sin_ready got=%b exp=1", sin_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL reset_out_perr got=%b exp=0", out_perr); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (perr_cnt !== 8'h00) begin errors++; $display("FAIL reset_perr_cnt got=%h exp=00", perr_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_good_frame;
        send_frame(4'hB, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 4'hB) begin errors++; $display("FAIL good_data got=%h exp=b", out_data); end
        checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL good_perr got=%b exp=0", out_perr); end
        checks++; if (perr_cnt !== 8'h00) begin errors++; $display("FAIL good_cnt got=%h exp=00", perr_cnt); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_consumed got=%b exp=0", out_valid); end
    endtask

    task automatic test_bad_parity;
        send_frame(4'hB, 1'b1);
        checks++; if (out_data !== 4'hB) begin errors++; $display("FAIL bad_data got=%h exp=b", out_data); end
        checks++; if (out_perr !== 1'b1) begin errors++; $display("FAIL bad_perr got=%b exp=1", out_perr); end
        checks++; if (perr_cnt !== 8'h01) begin errors++; $display("FAIL bad_cnt got=%h exp=01", perr_cnt); end
        send_frame(4'h0, 1'b1);
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL zero_data got=%h exp=0", out_data); end
        checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL zero_perr got=%b exp=0", out_perr); end
        checks++; if (perr_cnt !== 8'h01) begin errors++; $display("FAIL zero_cnt got=%h exp=01", perr_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        send_frame(4'h3, 1'b1);
        checks++; if (out_data !== 4'h3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_first valid=%b data=%h exp=1/3", out_valid, out_data); end
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        @(negedge clk);
        sin_valid = 1'b1;
        sin_bit   = 1'b1;
        #1;
        checks++; if (sin_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got=%b exp=0", sin_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== 4'h3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold valid=%b data=%h exp=1/3", out_valid, out_data); end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (sin_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", sin_ready); end
        @(posedge clk); #1;
        sin_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_nobubble got=%b exp=1", out_valid); end
        checks++; if (out_data !== 4'h5) begin errors++; $display("FAIL bp_second_data got=%h exp=5", out_data); end
        checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL bp_second_perr got=%b exp=0", out_perr); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_abort;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL abort_ferr got=%b exp=1", frame_err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_noword got=%b exp=0", out_valid); end
        send_bit(1'b0, 1'b1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL abort_pulse got=%b exp=0", frame_err); end
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_early got=%b exp=0", out_valid); end
        send_bit(1'b0, 1'b1);
        checks++; if (out_data !== 4'hA || out_valid !== 1'b1) begin errors++; $display("FAIL abort_data valid=%b data=%h exp=1/a", out_valid, out_data); end
        checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL abort_perr got=%b exp=0", out_perr); end
        checks++; if (perr_cnt !== 8'h01) begin errors++; $display("FAIL abort_cnt got=%h exp=01", perr_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_no_start;
        send_bit(1'b0, 1'b1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL nostart_ferr got=%b exp=1", frame_err); end
        send_bit(1'b0, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL nostart_idle got=%b exp=1", frame_err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nostart_noword got=%b exp=0", out_valid); end
        send_frame(4'hC, 1'b1);
        checks++; if (out_data !== 4'hC || out_perr !== 1'b0) begin errors++; $display("FAIL nostart_next data=%h perr=%b exp=c/0", out_data, out_perr); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL nostart_clear got=%b exp=0", frame_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send_frame(4'h6, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL rmid_data got=%h exp=0", out_data); end
        checks++; if (perr_cnt !== 8'h00) begin errors++; $display("FAIL rmid_cnt got=%h exp=00", perr_cnt); end
        checks++; if (sin_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", sin_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_frame(4'h9, 1'b0);
        checks++; if (out_data !== 4'h9 || out_valid !== 1'b1) begin errors++; $display("FAIL rmid_next valid=%b data=%h exp=1/9", out_valid, out_data); end
        checks++; if (out_perr !== 1'b1) begin errors++; $display("FAIL rmid_perr got=%b exp=1", out_perr); end
        checks++; if (perr_cnt !== 8'h01) begin errors++; $display("FAIL rmid_cnt_after got=%h exp=01", perr_cnt); end
    endtask

    task automatic test_saturation;
        for (int n = 0; n < 253; n++) send_frame(4'h0, 1'b0);
        checks++; if (perr_cnt !== 8'hFE) begin errors++; $display("FAIL sat_fe got=%h exp=fe", perr_cnt); end
        send_frame(4'h0, 1'b0);
        checks++; if (perr_cnt !== 8'hFF) begin errors++; $display("FAIL sat_ff got=%h exp=ff", perr_cnt); end
        for (int n = 0; n < 46; n++) send_frame(4'h0, 1'b0);
        checks++; if (perr_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold got=%h exp=ff", perr_cnt); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_parity;
        test_back_to_back;
        test_abort;
        test_no_start;
        test_reset_mid;
        test_saturation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
